// File: rtl/sevenseg_pkg.sv
// Shared constants, state encoding and pattern decode for the seven-segment scan decoder.
package sevenseg_pkg;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      ST_GAP    = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HELD   = 2'd2
   } scan_state_e;

   typedef struct packed {
      logic [3:0] nibble;
      logic       valid;
      logic       blank;
      logic       err;
   } seg_decode_t;

   function automatic seg_decode_t seg_decode(input logic [6:0] seg);
      seg_decode_t r;
      r = '{nibble: 4'h0, valid: 1'b1, blank: 1'b0, err: 1'b0};
      case (seg)
         SEG_0: r.nibble = 4'h0;
         SEG_1: r.nibble = 4'h1;
         SEG_2: r.nibble = 4'h2;
         SEG_3: r.nibble = 4'h3;
         SEG_4: r.nibble = 4'h4;
         SEG_5: r.nibble = 4'h5;
         SEG_6: r.nibble = 4'h6;
         SEG_7: r.nibble = 4'h7;
         SEG_8: r.nibble = 4'h8;
         SEG_9: r.nibble = 4'h9;
         SEG_A: r.nibble = 4'hA;
         SEG_B: r.nibble = 4'hB;
         SEG_C: r.nibble = 4'hC;
         SEG_D: r.nibble = 4'hD;
         SEG_E: r.nibble = 4'hE;
         SEG_F: r.nibble = 4'hF;
         SEG_BLANK: begin
            r.valid = 1'b0;
            r.blank = 1'b1;
         end
         default: begin
            r.valid = 1'b0;
            r.err   = 1'b1;
         end
      endcase
      return r;
   endfunction

   // True when exactly one anode select is driven low
   function automatic logic digit_one_hot_low(input logic [3:0] d);
      logic [3:0] a;
      a = ~d;
      return (a != 4'b0000) && ((a & (a - 4'd1)) == 4'b0000);
   endfunction

endpackage

// File: rtl/scan_stable_filter.sv
// Two-flop synchronizer plus dwell counter; accept_o strobes once per stable dwell.
module scan_stable_filter #(
   parameter int WIDTH         = 11,
   parameter int STABLE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] s_o,
   output logic             changed_o,
   output logic             accept_o
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

   logic [WIDTH-1:0] meta_q, s_q, p_q;
   logic [CW-1:0]    cnt_q, cnt_d;

   // Dwell count restarts on any change and parks at the maximum
   always_comb begin
      cnt_d = cnt_q;
      if (s_q != p_q) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Synchronizer, previous-sample and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         s_q    <= '0;
         p_q    <= '0;
         cnt_q  <= '0;
      end else begin
         meta_q <= din_i;
         s_q    <= meta_q;
         p_q    <= s_q;
         cnt_q  <= cnt_d;
      end
   end

   assign s_o       = s_q;
   assign changed_o = (s_q != p_q);
   assign accept_o  = (s_q == p_q) && (cnt_q == CNT_MAX - 1'b1);

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Recovers the four hex digits shown on an active-low multiplexed seven-segment bus.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_GAP   | no digit selected, or a multi-low select waiting to be flagged
// ST_SETTLE| one digit selected, waiting for the pins to hold still
// ST_HELD  | digit captured, waiting for the bus to move on
module sevenseg_scan_decoder
   import sevenseg_pkg::*;
#(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  DIGIT,
   input  logic [6:0]  DISPLAY,
   output logic [15:0] value,
   output logic [3:0]  digit_valid,
   output logic [3:0]  blank,
   output logic        frame_done,
   output logic        code_err,
   output logic        scan_err,
   output logic        stale
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);

   logic [10:0] s;
   logic        changed, accept;
   logic [3:0]  s_digit;
   logic        is_onehot, is_idle, is_multi, capture, timeout;
   logic [1:0]  idx;
   seg_decode_t dec;

   scan_state_e state_q;
   logic        scan_err_q;
   logic [15:0] shadow_nib_q, shadow_nib_d;
   logic [3:0]  shadow_vld_q, shadow_vld_d, shadow_blk_q, shadow_blk_d;
   logic [3:0]  seen_q, seen_d;
   logic [15:0] value_q, value_d;
   logic [3:0]  valid_q, valid_d, blank_q, blank_d;
   logic        frame_done_q, frame_done_d, code_err_q, code_err_d, stale_q, stale_d;
   logic [TW-1:0] to_q, to_d;

   scan_stable_filter #(
      .WIDTH         (11),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_filter (
      .clk       (clk),
      .rst       (rst),
      .din_i     ({DIGIT, DISPLAY}),
      .s_o       (s),
      .changed_o (changed),
      .accept_o  (accept)
   );

   assign s_digit   = s[10:7];
   assign is_onehot = digit_one_hot_low(s_digit);
   assign is_idle   = (s_digit == 4'b1111);
   assign is_multi  = !is_onehot && !is_idle;
   assign dec       = seg_decode(s[6:0]);
   assign capture   = accept && (state_q == ST_SETTLE) && is_onehot;
   assign timeout   = (to_q == '0) && !capture;

   // Digit position of the selected anode
   always_comb begin
      case (s_digit)
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
   end

   // Scan tracking FSM; flags multi-low selects once per dwell
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_GAP;
         scan_err_q <= 1'b0;
      end else begin
         scan_err_q <= 1'b0;
         case (state_q)
            ST_GAP: begin
               if (accept && is_multi) begin
                  scan_err_q <= 1'b1;
               end else if (is_onehot) begin
                  state_q <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (accept) begin
                  if (is_onehot) begin
                     state_q <= ST_HELD;
                  end else begin
                     state_q    <= ST_GAP;
                     scan_err_q <= is_multi;
                  end
               end else if (is_idle) begin
                  state_q <= ST_GAP;
               end
            end
            ST_HELD: begin
               if (changed) begin
                  state_q <= is_onehot ? ST_SETTLE : ST_GAP;
               end
            end
            default: state_q <= ST_GAP;
         endcase
      end
   end

   // Shadow capture, frame commit and staleness; a capture in the commit cycle
   // starts the next frame because commit reads the pre-capture shadow
   always_comb begin
      shadow_nib_d = shadow_nib_q;
      shadow_vld_d = shadow_vld_q;
      shadow_blk_d = shadow_blk_q;
      seen_d       = seen_q;
      value_d      = value_q;
      valid_d      = valid_q;
      blank_d      = blank_q;
      stale_d      = stale_q;
      frame_done_d = 1'b0;
      code_err_d   = 1'b0;
      to_d         = (to_q != '0) ? to_q - 1'b1 : to_q;
      if (timeout) begin
         stale_d = 1'b1;
         value_d = '0;
         valid_d = '0;
         blank_d = '0;
         seen_d  = '0;
      end
      if (seen_q == 4'b1111) begin
         value_d      = shadow_nib_q;
         valid_d      = shadow_vld_q;
         blank_d      = shadow_blk_q;
         frame_done_d = 1'b1;
         stale_d      = 1'b0;
         seen_d       = '0;
      end
      if (capture) begin
         to_d                        = TO_LOAD;
         seen_d[idx]                 = 1'b1;
         shadow_nib_d[{idx, 2'b00} +: 4] = dec.nibble;
         shadow_vld_d[idx]           = dec.valid;
         shadow_blk_d[idx]           = dec.blank;
         code_err_d                  = dec.err;
      end
   end

   // Frame and timeout registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_nib_q <= '0;
         shadow_vld_q <= '0;
         shadow_blk_q <= '0;
         seen_q       <= '0;
         value_q      <= '0;
         valid_q      <= '0;
         blank_q      <= '0;
         stale_q      <= 1'b1;
         frame_done_q <= 1'b0;
         code_err_q   <= 1'b0;
         to_q         <= '0;
      end else begin
         shadow_nib_q <= shadow_nib_d;
         shadow_vld_q <= shadow_vld_d;
         shadow_blk_q <= shadow_blk_d;
         seen_q       <= seen_d;
         value_q      <= value_d;
         valid_q      <= valid_d;
         blank_q      <= blank_d;
         stale_q      <= stale_d;
         frame_done_q <= frame_done_d;
         code_err_q   <= code_err_d;
         to_q         <= to_d;
      end
   end

   assign value       = value_q;
   assign digit_valid = valid_q;
   assign blank       = blank_q;
   assign frame_done  = frame_done_q;
   assign code_err    = code_err_q;
   assign scan_err    = scan_err_q;
   assign stale       = stale_q;

endmodule

// File: doc/sevenseg_scan_decoder.md
Name: sevenseg_scan_decoder

Overview:
- Listens to a multiplexed, active-low 4-digit seven-segment scan bus (DIGIT/DISPLAY) driven by a game or display block.
- Recovers the hex value shown on each digit and reports it as a 16-bit word.
- Used as a board-to-board readback monitor and as a self-check in simulation.
- Contains the input synchronizer, stability filter, pattern decoder, frame assembler and staleness timeout.

Parameters:
- STABLE_CYCLES, 16, consecutive identical synchronized samples required to accept a digit (≥2).
- TIMEOUT_CYCLES, 1048576, cycles without any accepted digit before outputs go stale.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- DIGIT  in  4  anode select, active-low one-hot; 4'b1110 = digit0 (rightmost), 4'b0111 = digit3
- DISPLAY  in  7  segments, active-low, DISPLAY[6:0] = {g,f,e,d,c,b,a}
- value  out  16  committed nibbles, [3:0] = digit0 … [15:12] = digit3
- digit_valid  out  4  committed nibble decoded to 0–F
- blank  out  4  committed digit was all segments off
- frame_done  out  1  one-cycle pulse when a new frame commits
- code_err  out  1  one-cycle pulse when an unrecognized segment pattern is accepted
- scan_err  out  1  one-cycle pulse when a stable DIGIT with more than one low bit is seen
- stale  out  1  no valid frame committed, or timeout expired

Behaviour:
- Reset (asynchronous): value, digit_valid, blank = 0; frame_done, code_err, scan_err = 0; stale = 1. Synchronizers, counters, shadow registers and seen mask are cleared; FSM goes to GAP.
- Reset mid-frame discards partial shadow contents. No partial commit.
- Synchronization: DIGIT and DISPLAY pass through a 2-FF synchronizer to give s. Register p holds the previous value of s.
- Stability counter cnt:
  - Cleared when s ≠ p.
  - Otherwise increments, saturating at STABLE_CYCLES.
  - Accept strobe fires on the single cycle cnt goes STABLE_CYCLES-1 → STABLE_CYCLES. Exactly one accept per dwell.
- Latency: a pin change held steady updates the shadow registers STABLE_CYCLES+3 clk edges after the change.
- FSM states:
  - GAP: s.DIGIT == 4'b1111 or not yet stable. Goes to SETTLE when s.DIGIT has exactly one low bit.
  - SETTLE: counting. Goes to HELD on accept. Goes back to GAP if s.DIGIT becomes 4'b1111. Any other change of s restarts the count and stays in SETTLE.
  - HELD: waits for s to change. Goes to SETTLE if the new DIGIT is one-hot-low, otherwise to GAP.
  - A stable DIGIT with two or more low bits pulses scan_err once per dwell, captures nothing, and stays in GAP.
- Decode on accept:
  - Patterns 0–F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
  - 1111111 means blank: nibble 0, valid 0, blank 1.
  - Any other pattern: code_err pulse, nibble 0, valid 0, blank 0.
  - In every case the digit's seen bit is set and its shadow entry is overwritten. Re-capturing the same digit before the frame completes replaces the earlier entry.
- Frame commit:
  - Triggered when seen becomes 4'b1111.
  - On the next cycle: shadow is copied to value/digit_valid/blank, frame_done pulses, seen clears, stale is cleared.
  - If a new accept coincides with the commit cycle, the commit uses the pre-accept shadow and the new accept lands in the next frame's shadow with its seen bit set.
- Timeout:
  - Counter resets on every accept.
  - On reaching TIMEOUT_CYCLES: stale = 1; value, digit_valid, blank cleared; seen cleared.
  - Stays stale until the next frame_done.
  - If timeout and accept occur in the same cycle, the accept wins.

Decomposition:
- Package sevenseg_pkg holds:
  - the 16 segment-pattern constants and SEG_BLANK;
  - FSM state encoding (GAP, SETTLE, HELD);
  - a pure decode function mapping 7 bits to {nibble, valid, blank, err}.
- Sub-module scan_stable_filter: synchronizer, p register, cnt, accept strobe, parameterised by width and STABLE_CYCLES. The FSM, frame assembler and timeout live in the top module.

Test Plan:
- Scan of 1,2,3,4 (DIGIT 0111/1011/1101/1110, 40 cycles each, 4-cycle 1111 gaps, STABLE_CYCLES=16) → value=16'h1234, digit_valid=4'hF, blank=0, frame_done single pulse, stale 1→0.
- Digit0 DISPLAY glitches (one sample of 0000000 inside a 0100100 dwell, 30-cycle dwell) → no accept from the glitch; committed nibble0 = 2; first accept at STABLE_CYCLES+3 after the settled edge.
- Digit2 pattern 0101010 → code_err one pulse; after frame: digit_valid=4'b1011, value[11:8]=0, no scan_err.
- DIGIT=4'b1100 held 40 cycles → scan_err exactly one pulse, seen unchanged, no frame_done.
- Valid frame, then scan stops, TIMEOUT_CYCLES=1000 → stale=1 and value=0 at cycle 1000 after the last accept; a resumed full scan clears stale at frame_done.
- rst asserted asynchronously mid-frame after 2 digits, then a full scan of A,b,C,d → outputs 0/stale=1 during reset; first commit value=16'hABCD with no leftover digits from the discarded frame.
